// File: rtl/test_sequencer.sv
// test_sequencer: drives operand vectors into a core's data memory, runs the core, and checks its sum result
// Ports: clk/reset (async active-low); start begins a run; vec_idx selects vec_a/vec_b;
//        mem_we/mem_addr/mem_wdata/mem_rdata access core data memory (1-cycle read latency);
//        core_reset/core_done control the core; busy/pass/fail/timeout_flag/err_count report status.
module test_sequencer #(
  parameter int DW = 8,
  parameter int AW = 8,
  parameter int NUM_TESTS = 4,
  parameter int TIMEOUT = 255,
  parameter int ADDR_A = 0,
  parameter int ADDR_B = 1,
  parameter int ADDR_R = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [15:0]   vec_idx,
  input  logic [DW-1:0] vec_a,
  input  logic [DW-1:0] vec_b,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          core_reset,
  input  logic          core_done,
  output logic          busy,
  output logic          pass,
  output logic          fail,
  output logic          timeout_flag,
  output logic [15:0]   err_count
);
  localparam int CW = $clog2(TIMEOUT + 2);
  typedef enum logic [3:0] {IDLE, LOAD_A, LOAD_B, RST1, RST2, RUN, READ, CHECK, NEXT, DONE} state_t;
  state_t state_q, state_d;
  logic [15:0] idx_q, idx_d, err_q, err_d, err_sat;
  logic [CW-1:0] cnt_q, cnt_d;
  logic tmo_q, tmo_d, crst_q, crst_d;
  logic [DW-1:0] sum;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    err_d = err_q;
    tmo_d = tmo_q;
    cnt_d = state_q == RUN && !core_done ? cnt_q + CW'(1) : '0;
    sum = vec_a + vec_b;
    err_sat = err_q == 16'hFFFF ? err_q : err_q + 16'd1;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = LOAD_A;
        idx_d = '0;
        err_d = '0;
        tmo_d = 1'b0;
      end
      LOAD_A: state_d = LOAD_B;
      LOAD_B: state_d = RST1;
      RST1: state_d = RST2;
      RST2: state_d = RUN;
      // core_done takes priority over an expiring timeout in the same cycle
      RUN: if (core_done) state_d = READ;
        else if (cnt_q == CW'(TIMEOUT)) begin
          state_d = NEXT;
          tmo_d = 1'b1;
          err_d = err_sat;
        end
      READ: state_d = CHECK;
      CHECK: begin
        state_d = NEXT;
        if (mem_rdata != sum) err_d = err_sat;
      end
      NEXT: if (idx_q == 16'(NUM_TESTS - 1)) state_d = DONE;
        else begin
          state_d = LOAD_A;
          idx_d = idx_q + 16'd1;
        end
      default: state_d = IDLE;
    endcase
    // registered so the core stays in reset while ours is asserted, and for exactly RST1/RST2
    crst_d = state_d inside {RST1, RST2};
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      err_q <= '0;
      cnt_q <= '0;
      tmo_q <= 1'b0;
      crst_q <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
      crst_q <= crst_d;
    end
  end
  assign mem_we = state_q inside {LOAD_A, LOAD_B};
  assign mem_addr = state_q == LOAD_A ? AW'(ADDR_A) : state_q == LOAD_B ? AW'(ADDR_B) :
                    state_q == READ ? AW'(ADDR_R) : '0;
  assign mem_wdata = state_q == LOAD_A ? vec_a : state_q == LOAD_B ? vec_b : '0;
  assign busy = !(state_q inside {IDLE, DONE});
  assign pass = state_q == DONE && err_q == '0;
  assign fail = state_q == DONE && err_q != '0;
  assign vec_idx = idx_q;
  assign err_count = err_q;
  assign timeout_flag = tmo_q;
  assign core_reset = crst_q;
endmodule

// File: tb/tb_test_sequencer.sv
// tb_test_sequencer: table-driven and randomized runs against a memory/core model and a per-vector outcome model
module tb_test_sequencer;
  localparam int TMO = 10;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [15:0] vec_idx, err_count;
  logic [7:0] vec_a, vec_b, mem_addr, mem_wdata, mem_rdata;
  logic mem_we, core_reset, core_done, busy, pass, fail, timeout_flag;
  logic [7:0] mem [256];
  logic [7:0] va [4], vb [4], dl [4];
  int lat [4];
  int ccnt = 0;
  int total = 0, bad = 0;
  typedef struct {
    logic [3:0][7:0] a, b, dl, lat;
    int err;
    bit tmo;
  } vec_t;
  vec_t tbl [5];

  test_sequencer #(.DW(8), .AW(8), .NUM_TESTS(4), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .vec_idx(vec_idx), .vec_a(vec_a), .vec_b(vec_b),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .core_reset(core_reset), .core_done(core_done), .busy(busy), .pass(pass), .fail(fail),
    .timeout_flag(timeout_flag), .err_count(err_count));

  always #5 clk = ~clk;

  assign vec_a = va[vec_idx[1:0]];
  assign vec_b = vb[vec_idx[1:0]];
  // core finishes in RUN cycle lat-1 (lat RUN cycles), having written A+B+dl to the result slot
  assign core_done = !core_reset && ccnt >= lat[vec_idx[1:0]] - 1;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
    if (core_reset) begin
      ccnt <= 0;
      mem[2] <= ~(mem[0] + mem[1] + dl[vec_idx[1:0]]);
    end else begin
      ccnt <= ccnt + 1;
      if (ccnt == 0) mem[2] <= mem[0] + mem[1] + dl[vec_idx[1:0]];
    end
  end

  task automatic chk(input string n, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic load(input vec_t t);
    for (int i = 0; i < 4; i++) begin
      va[i] = t.a[i];
      vb[i] = t.b[i];
      dl[i] = t.dl[i];
      lat[i] = int'(t.lat[i]);
    end
  endtask

  // outcome of a run: a hung vector costs 4 setup + TMO+1 RUN + NEXT cycles, a finished one 7+lat
  function automatic void model(output int e, output bit tm, output int c);
    e = 0;
    tm = 1'b0;
    c = 0;
    for (int i = 0; i < 4; i++) begin
      if (lat[i] > TMO + 1) begin
        tm = 1'b1;
        e++;
        c += 4 + TMO + 1 + 1;
      end else begin
        c += 7 + lat[i];
        if (dl[i] != 0) e++;
      end
    end
  endfunction

  task automatic do_run(input int inj, output int cyc);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("load_we", mem_we, 1);
    chk("load_addr", mem_addr, 0);
    chk("load_wdata", mem_wdata, va[0]);
    chk("start_clr_err", err_count, 0);
    chk("start_clr_tmo", timeout_flag, 0);
    chk("start_clr_passfail", {pass, fail}, 0);
    chk("start_clr_idx", vec_idx, 0);
    cyc = 0;
    while (busy && cyc < 500) begin
      cyc++;
      start = (cyc == inj);
      @(negedge clk);
    end
    start = 1'b0;
    if (cyc >= 500) begin
      total++;
      bad++;
      $display("FAIL run_hang: busy still 1 after %0d cycles, expected 0", cyc);
    end
  endtask

  task automatic check_end(input int e, input bit tm, input int ce, input int c);
    chk("end_err", err_count, e);
    chk("end_tmo", timeout_flag, tm);
    chk("end_pass", pass, e == 0);
    chk("end_fail", fail, e != 0);
    chk("end_idx", vec_idx, 3);
    chk("end_busy", busy, 0);
    chk("end_core_reset", core_reset, 0);
    chk("run_cycles", c, ce);
    repeat (3) @(negedge clk);
    chk("done_hold", {pass, fail}, {e == 0, e != 0});
  endtask

  initial begin
    int c, e, ce;
    bit tm;
    tbl[0] = '{a: {8'd200, 8'd100, 8'd10, 8'd1}, b: {8'd100, 8'd50, 8'd20, 8'd2}, dl: '0,
               lat: {8'd11, 8'd6, 8'd5, 8'd1}, err: 0, tmo: 1'b0};
    tbl[1] = '{a: {8'd7, 8'd6, 8'd5, 8'd4}, b: {8'd3, 8'd3, 8'd3, 8'd3}, dl: {8'd0, 8'd1, 8'd0, 8'd0},
               lat: {8'd3, 8'd3, 8'd3, 8'd3}, err: 1, tmo: 1'b0};
    tbl[2] = '{a: {8'hFF, 8'h80, 8'hFF, 8'hFF}, b: {8'hFF, 8'h80, 8'h01, 8'h02}, dl: '0,
               lat: {8'd2, 8'd2, 8'd2, 8'd2}, err: 0, tmo: 1'b0};
    tbl[3] = '{a: {8'd9, 8'd8, 8'd7, 8'd6}, b: {8'd1, 8'd1, 8'd1, 8'd1}, dl: '0,
               lat: {8'd2, 8'd2, 8'd12, 8'd2}, err: 1, tmo: 1'b1};
    tbl[4] = '{a: {8'd40, 8'd30, 8'd20, 8'd10}, b: {8'd4, 8'd3, 8'd2, 8'd1}, dl: {8'd0, 8'd0, 8'd5, 8'd1},
               lat: {8'd12, 8'd2, 8'd11, 8'd1}, err: 3, tmo: 1'b1};
    load(tbl[0]);
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_passfail", {pass, fail}, 0);
    chk("rst_tmo", timeout_flag, 0);
    chk("rst_err", err_count, 0);
    chk("rst_idx", vec_idx, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_core_reset", core_reset, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_core_reset", core_reset, 0);
    chk("post_rst_busy", busy, 0);
    for (int i = 0; i < 5; i++) begin
      load(tbl[i]);
      do_run(i == 1 ? 6 : 0, c);
      model(e, tm, ce);
      chk("tbl_err", err_count, tbl[i].err);
      chk("tbl_tmo", timeout_flag, tbl[i].tmo);
      check_end(e, tm, ce, c);
    end
    load(tbl[0]);
    lat[0] = 12;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (19) @(negedge clk);
    chk("abort_pre_err", err_count, 1);
    chk("abort_pre_tmo", timeout_flag, 1);
    chk("abort_pre_busy", busy, 1);
    reset = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_core_reset", core_reset, 1);
    chk("abort_err", err_count, 0);
    chk("abort_tmo", timeout_flag, 0);
    chk("abort_idx", vec_idx, 0);
    chk("abort_we", mem_we, 0);
    chk("abort_passfail", {pass, fail}, 0);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    chk("abort_post_core_reset", core_reset, 0);
    load(tbl[0]);
    do_run(0, c);
    model(e, tm, ce);
    check_end(e, tm, ce, c);
    repeat (6) begin
      for (int i = 0; i < 4; i++) begin
        va[i] = 8'($urandom);
        vb[i] = 8'($urandom);
        lat[i] = int'($urandom_range(1, 13));
        dl[i] = $urandom_range(0, 2) == 0 ? 8'($urandom_range(1, 255)) : 8'd0;
      end
      do_run(int'($urandom_range(0, 20)), c);
      model(e, tm, ce);
      check_end(e, tm, ce, c);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
